// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared SRAM arbiter and client state encodings
package sram_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_READ,
    ARB_WRITE
  } arb_state_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_REQ,
    RD_STALL,
    RD_DRAIN
  } reader_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with occupancy count and flush
module sync_fifo #(
  parameter int WIDTH       = 16,
  parameter int DEPTH       = 4,
  parameter int COUNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   empty
);
  localparam int PTR_WIDTH = $clog2(DEPTH);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic                 full;
  logic                 do_push;
  logic                 do_pop;

  assign empty    = (count == '0);
  assign full     = (count == COUNT_WIDTH'(DEPTH));
  assign do_pop   = pop && !empty && !flush;
  // a push into a full FIFO is accepted only when the head leaves in the same cycle
  assign do_push  = push && !flush && (!full || do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + COUNT_WIDTH'(1);
      end else if (do_pop && !do_push) begin
        count <= count - COUNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/sram_stream_reader.sv
// rtl/sram_stream_reader.sv - sequential burst reader from the SRAM arbiter onto a ready/valid stream
module sram_stream_reader
  import sram_pkg::*;
#(
  parameter int ADDRESS_BUS_WIDTH = 16,
  parameter int DATA_BUS_WIDTH    = 16,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic [ADDRESS_BUS_WIDTH-1:0] base_address,
  input  logic [ADDRESS_BUS_WIDTH-1:0] length,
  output logic                         busy,
  output logic                         done,
  output logic                         read_request,
  output logic [ADDRESS_BUS_WIDTH-1:0] read_address,
  input  logic                         read_finished_strobe,
  input  logic [DATA_BUS_WIDTH-1:0]    read_data,
  output logic [DATA_BUS_WIDTH-1:0]    out_data,
  output logic                         out_valid,
  input  logic                         out_ready
);
  localparam int COUNT_WIDTH = $clog2(FIFO_DEPTH + 1);
  localparam logic [COUNT_WIDTH-1:0] DEPTH_COUNT = COUNT_WIDTH'(FIFO_DEPTH);

  reader_state_t                state_q, state_d;
  logic [ADDRESS_BUS_WIDTH-1:0] addr_q, addr_d;
  logic [ADDRESS_BUS_WIDTH-1:0] remaining_q, remaining_d;
  logic                         pending_q, pending_d;
  logic                         done_q, done_d;
  logic                         push;
  logic                         pop;
  logic                         flush;
  logic                         fifo_empty;
  logic [COUNT_WIDTH-1:0]       fifo_count;
  logic [COUNT_WIDTH-1:0]       count_next;

  assign push       = (state_q == RD_REQ) && read_finished_strobe;
  assign flush      = abort && (state_q != RD_IDLE);
  assign pop        = out_valid && out_ready;
  assign count_next = fifo_count + COUNT_WIDTH'(push) - COUNT_WIDTH'(pop);

  // masking with the strobe stops the arbiter re-granting the read it is just completing
  assign read_request = pending_q && !read_finished_strobe;
  assign read_address = addr_q;
  assign out_valid    = !fifo_empty;
  assign done         = done_q;
  assign busy         = (state_q != RD_IDLE) || done_q;

  sync_fifo #(
    .WIDTH      (DATA_BUS_WIDTH),
    .DEPTH      (FIFO_DEPTH),
    .COUNT_WIDTH(COUNT_WIDTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .push     (push),
    .push_data(read_data),
    .pop      (pop),
    .pop_data (out_data),
    .count    (fifo_count),
    .empty    (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    pending_d   = pending_q;
    done_d      = 1'b0;
    case (state_q)
      RD_IDLE: begin
        if (start && !abort && !done_q) begin
          addr_d      = base_address;
          remaining_d = length;
          if (length == '0) begin
            state_d = RD_DRAIN;
          end else begin
            state_d   = RD_REQ;
            pending_d = 1'b1;
          end
        end
      end
      RD_REQ: begin
        if (read_finished_strobe) begin
          pending_d   = 1'b0;
          addr_d      = addr_q + ADDRESS_BUS_WIDTH'(1);
          remaining_d = remaining_q - ADDRESS_BUS_WIDTH'(1);
          if (remaining_q == ADDRESS_BUS_WIDTH'(1)) begin
            state_d = RD_DRAIN;
          end else if (count_next < DEPTH_COUNT) begin
            pending_d = 1'b1;
          end else begin
            state_d = RD_STALL;
          end
        end
      end
      RD_STALL: begin
        if (count_next < DEPTH_COUNT) begin
          state_d   = RD_REQ;
          pending_d = 1'b1;
        end
      end
      RD_DRAIN: begin
        if (count_next == '0) begin
          state_d = RD_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = RD_IDLE;
    endcase
    if (flush) begin
      state_d   = RD_IDLE;
      pending_d = 1'b0;
      done_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RD_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      pending_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      pending_q   <= pending_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_sram_stream_reader.sv
// tb/tb_sram_stream_reader.sv - scoreboard bench for sram_stream_reader against an arbiter model
module tb_sram_stream_reader;
  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [AW-1:0] base_address;
  logic [AW-1:0] length;
  logic          busy;
  logic          done;
  logic          read_request;
  logic [AW-1:0] read_address;
  logic          read_finished_strobe;
  logic [DW-1:0] read_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  always #5 clk = ~clk;

  sram_stream_reader #(
    .ADDRESS_BUS_WIDTH(AW),
    .DATA_BUS_WIDTH   (DW),
    .FIFO_DEPTH       (4)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .abort               (abort),
    .base_address        (base_address),
    .length              (length),
    .busy                (busy),
    .done                (done),
    .read_request        (read_request),
    .read_address        (read_address),
    .read_finished_strobe(read_finished_strobe),
    .read_data           (read_data),
    .out_data            (out_data),
    .out_valid           (out_valid),
    .out_ready           (out_ready)
  );

  int            checks = 0;
  int            failures = 0;
  logic [AW-1:0] exp_addr[$];
  logic [DW-1:0] exp_data[$];
  logic [DW-1:0] key;
  int            lat_fixed = 0;
  bit            beef_mode = 1'b0;
  bit            arb_busy = 1'b0;
  int            n_req = 0;
  int            done_count = 0;
  int            ready_mode = 0;

  function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
    return (a * 16'd40503) ^ key;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // arbiter model: grants one read after a latency and strobes its data
  initial begin : arbiter
    logic [AW-1:0] a;
    int            lat;
    read_finished_strobe = 1'b0;
    read_data = '0;
    forever begin
      @(posedge clk);
      #1;
      read_finished_strobe = 1'b0;
      read_data = DW'($urandom);
      if (read_request) begin
        arb_busy = 1'b1;
        a = read_address;
        n_req++;
        checks++;
        if (exp_addr.size() == 0) begin
          failures++;
          $display("FAIL unexpected_request actual=0x%0h expected=none", a);
        end else if (a !== exp_addr[0]) begin
          failures++;
          $display("FAIL read_address actual=0x%0h expected=0x%0h", a, exp_addr[0]);
          void'(exp_addr.pop_front());
        end else begin
          void'(exp_addr.pop_front());
        end
        lat = (lat_fixed != 0) ? lat_fixed : $urandom_range(1, 3);
        repeat (lat) begin
          @(posedge clk);
          #1;
        end
        read_finished_strobe = 1'b1;
        read_data = beef_mode ? 16'hBEEF : data_of(a);
        @(negedge clk);
        chk("request_masked_in_strobe", 32'(read_request), 32'd0);
        arb_busy = 1'b0;
      end
    end
  end

  initial begin : ready_drv
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
    end
  end

  always @(negedge clk) begin : monitor
    logic [DW-1:0] w;
    if (!rst) begin
      if (done) done_count++;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_data.size() == 0) begin
          failures++;
          $display("FAIL unexpected_word actual=0x%0h expected=none", out_data);
        end else begin
          w = exp_data.pop_front();
          if (out_data !== w) begin
            failures++;
            $display("FAIL out_data actual=0x%0h expected=0x%0h", out_data, w);
          end
        end
      end
    end
  end

  task automatic pulse_start(input logic [AW-1:0] b, input logic [AW-1:0] len);
    exp_addr.delete();
    exp_data.delete();
    for (int i = 0; i < int'(len); i++) begin
      exp_addr.push_back(b + AW'(i));
      exp_data.push_back(data_of(b + AW'(i)));
    end
    base_address = b;
    length = len;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic finish_burst(input string name, input int d0, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done"}, 32'(done), 32'd1);
    chk({name, "_busy_in_done"}, 32'(busy), 32'd1);
    @(negedge clk);
    chk({name, "_busy_after"}, 32'(busy), 32'd0);
    chk({name, "_done_after"}, 32'(done), 32'd0);
    @(posedge clk);
    #1;
    chk({name, "_done_pulses"}, 32'(done_count - d0), 32'd1);
    chk({name, "_words_left"}, 32'(exp_data.size()), 32'd0);
    chk({name, "_addrs_left"}, 32'(exp_addr.size()), 32'd0);
  endtask

  task automatic wait_arb_idle();
    int n = 0;
    while (arb_busy && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("arbiter_idle", 32'(arb_busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin : stimulus
    int  d0;
    int  r0;
    int  n;
    bit  any_valid;
    key = DW'($urandom);
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    base_address = '0;
    length = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_read_request", 32'(read_request), 32'd0);
    chk("rst_read_address", 32'(read_address), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // bank boundary crossing with a fixed 2-cycle arbiter
    lat_fixed = 2;
    ready_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    d0 = done_count;
    r0 = n_req;
    pulse_start(16'h3FFE, 16'd4);
    finish_burst("bank", d0, 100);
    chk("bank_requests", 32'(n_req - r0), 32'd4);

    // backpressure: only FIFO_DEPTH reads issue before the stall
    lat_fixed = 0;
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    d0 = done_count;
    r0 = n_req;
    pulse_start(16'h1230, 16'd6);
    repeat (40) @(negedge clk);
    chk("stall_requests", 32'(n_req - r0), 32'd4);
    chk("stall_no_request", 32'(read_request), 32'd0);
    chk("stall_busy", 32'(busy), 32'd1);
    chk("stall_out_valid", 32'(out_valid), 32'd1);
    ready_mode = 1;
    finish_burst("stall", d0, 100);
    chk("stall_total_requests", 32'(n_req - r0), 32'd6);

    // zero length
    d0 = done_count;
    r0 = n_req;
    pulse_start(16'h0040, 16'd0);
    @(negedge clk);
    chk("zero_busy_e0", 32'(busy), 32'd1);
    chk("zero_done_e0", 32'(done), 32'd0);
    @(negedge clk);
    chk("zero_done_e1", 32'(done), 32'd1);
    @(negedge clk);
    chk("zero_done_e2", 32'(done), 32'd0);
    chk("zero_busy_e2", 32'(busy), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("zero_requests", 32'(n_req - r0), 32'd0);
    chk("zero_done_pulses", 32'(done_count - d0), 32'd1);

    // abort with a read in flight; the late 0xBEEF strobe must be dropped
    ready_mode = 0;
    lat_fixed = 3;
    beef_mode = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    d0 = done_count;
    pulse_start(16'h5000, 16'd3);
    n = 0;
    while (!read_request && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("abort_request_seen", 32'(read_request), 32'd1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    exp_addr.delete();
    exp_data.delete();
    @(negedge clk);
    chk("abort_done", 32'(done), 32'd1);
    chk("abort_request_dropped", 32'(read_request), 32'd0);
    any_valid = 1'b0;
    repeat (8) begin
      @(negedge clk);
      any_valid |= out_valid;
    end
    chk("abort_no_word", 32'(any_valid), 32'd0);
    chk("abort_busy_after", 32'(busy), 32'd0);
    chk("abort_done_pulses", 32'(done_count - d0), 32'd1);
    wait_arb_idle();
    beef_mode = 1'b0;
    lat_fixed = 0;
    ready_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    d0 = done_count;
    pulse_start(16'h5000, 16'd2);
    finish_burst("after_abort", d0, 100);

    // address wrap
    d0 = done_count;
    pulse_start(16'hFFFF, 16'd2);
    finish_burst("wrap", d0, 100);

    // random bursts with random backpressure and latency
    ready_mode = 2;
    for (int it = 0; it < 12; it++) begin
      d0 = done_count;
      pulse_start(AW'($urandom), AW'($urandom_range(1, 9)));
      finish_burst("random", d0, 300);
    end

    // reset in the middle of a burst
    ready_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    pulse_start(16'h0100, 16'd8);
    repeat ($urandom_range(2, 8)) @(posedge clk);
    #1;
    n = 0;
    while (!read_request && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("midrst_request_seen", 32'(read_request), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_read_request", 32'(read_request), 32'd0);
    chk("midrst_read_address", 32'(read_address), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_addr.delete();
    exp_data.delete();
    wait_arb_idle();
    d0 = done_count;
    pulse_start(16'h0A00, 16'd5);
    finish_burst("after_rst", d0, 200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
